// File: rtl/imem_pkg.sv
// Shared widths, legal read-latency range and response entry layout for the fetch memory.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imem_pkg;
  localparam int IMEM_DATA_W  = 32;
  localparam int IMEM_ADDR_W  = 9;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] data;
  } rspEntry_t;
endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response, program-load and flush signals between IF stage and instruction memory.
// Latency: none (wiring only).
// Backpressure: req_ready from memory side, rsp_ready from IF side.
interface imem_fetch_if import imem_pkg::*; #(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) ();
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              flush;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_ready;

  modport master (
    output load_en, load_addr, load_data, flush, req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  load_en, load_addr, load_data, flush, req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/imem_rsp_fifo.sv
// Circular first-word-fall-through response buffer with occupancy count and synchronous clear.
// Latency: a push is visible at the head in the cycle after the write edge.
// Backpressure: none internally; the caller must never push while full (checked by assertion).
module imem_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  pushDat,
  input  logic          pop,
  output logic [W-1:0]  popDat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [W-1:0]  lastQ;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          notEmpty;
  logic          doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign notEmpty = (count != '0);
  assign doPop    = pop && notEmpty;
  // When empty the output keeps showing whatever it showed last.
  assign popDat   = notEmpty ? store[rdPtr] : lastQ;

  // Entry storage and the hold register behind the empty-case output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      lastQ <= '0;
    end else begin
      if (push && !clear) store[wrPtr] <= pushDat;
      lastQ <= popDat;
    end
  end

  // Pointers wrap modulo DEPTH; clear empties the buffer without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push)  wrPtr <= nextPtr(wrPtr);
      if (doPop) rdPtr <= nextPtr(rdPtr);
      if (push && !doPop)      count <= count + CW'(1);
      else if (!push && doPop) count <= count - CW'(1);
    end
  end

  pushWhileFull: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !clear && count == CW'(DEPTH)));
endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with program-load port, pipelined fetch and buffered in-order responses.
// Latency: accept-to-rsp_valid of READ_LAT cycles (1 or 2).
// Backpressure: req_ready drops once pipeline+buffer hold RSP_DEPTH words, or during load/flush.
module imem_fetch import imem_pkg::*; #(
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 2
) (
  input logic         clk,
  input logic         reset_n,
  imem_fetch_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] memArr [2**ADDR_W];
  logic [CW-1:0]     outCnt;
  logic [CW-1:0]     fifoCnt;
  logic              accept;
  logic              pop;
  logic              fifoPush;
  entry_t            rdEntry;
  entry_t            fifoIn;
  entry_t            fifoOut;

  // outCnt counts words in the read pipeline plus the buffer, so the buffer can never overflow.
  assign bus.req_ready = !bus.load_en && !bus.flush && (outCnt < CW'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  // Load and accept are mutually exclusive, so this read never races a write.
  assign rdEntry       = '{addr: bus.req_addr, data: memArr[bus.req_addr]};

  // Program load; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (bus.load_en) memArr[bus.load_addr] <= bus.load_data;
  end

  // Outstanding words: +1 on accept, -1 on pop, zeroed by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                outCnt <= '0;
    else if (bus.flush)          outCnt <= '0;
    else if (accept && !pop)     outCnt <= outCnt + CW'(1);
    else if (!accept && pop)     outCnt <= outCnt - CW'(1);
  end

  if (READ_LAT > READ_LAT_MIN) begin : gPipe
    logic   pipeVld;
    entry_t pipeQ;

    // One register stage between array read and buffer; flush never coincides with accept.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipeVld <= 1'b0;
        pipeQ   <= '0;
      end else begin
        pipeVld <= accept;
        if (accept) pipeQ <= rdEntry;
      end
    end

    assign fifoPush = pipeVld;
    assign fifoIn   = pipeQ;
  end else begin : gDirect
    assign fifoPush = accept;
    assign fifoIn   = rdEntry;
  end

  imem_rsp_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (RSP_DEPTH)
  ) rspFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.flush),
    .push    (fifoPush),
    .pushDat (fifoIn),
    .pop     (pop),
    .popDat  (fifoOut),
    .count   (fifoCnt)
  );

  assign bus.rsp_valid = (fifoCnt != '0);
  assign bus.rsp_data  = fifoOut.data;
  assign bus.rsp_addr  = fifoOut.addr;
endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_if #(.DATA_W(32), .ADDR_W(9)) bA ();
  imem_fetch_if #(.DATA_W(32), .ADDR_W(9)) bB ();

  imem_fetch #(.DATA_W(32), .ADDR_W(9), .READ_LAT(1), .RSP_DEPTH(2)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(bA.slave));
  imem_fetch #(.DATA_W(32), .ADDR_W(9), .READ_LAT(2), .RSP_DEPTH(3)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(bB.slave));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] model [512];
  rspEntry_t   sbq  [2][$];
  int          accq [2][$];
  logic [31:0] seen [2][$];
  int          accCnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step for one DUT, sampled mid-cycle before the coming edge.
  task automatic mon(input int id, input int lat, input int depth,
                     input logic rv, input logic rr, input logic qv, input logic qr,
                     input logic [8:0] qa, input logic [8:0] ra, input logic [31:0] rd,
                     input logic le, input logic fl);
    logic expRv;
    logic expQr;
    expRv = 1'b0;
    if (sbq[id].size() != 0) expRv = (cyc >= accq[id][0] + lat - 1);
    expQr = !le && !fl && (sbq[id].size() < depth);
    chk($sformatf("rsp_valid%0d", id), rv, expRv);
    chk($sformatf("req_ready%0d", id), qr, expQr);
    if (rv && rr) begin
      chk($sformatf("sb_nonempty%0d", id), sbq[id].size() != 0, 1);
      if (sbq[id].size() != 0) begin
        chk($sformatf("rsp_data%0d", id), rd, sbq[id][0].data);
        chk($sformatf("rsp_addr%0d", id), ra, sbq[id][0].addr);
        if (!fl) seen[id].push_back(rd);
        void'(sbq[id].pop_front());
        void'(accq[id].pop_front());
      end
    end
    if (fl) begin
      sbq[id].delete();
      accq[id].delete();
    end
    if (qv && qr) begin
      sbq[id].push_back('{addr: qa, data: model[qa]});
      accq[id].push_back(cyc + 1);
      accCnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        sbq[i].delete();
        accq[i].delete();
      end
    end else begin
      mon(0, 1, 2, bA.rsp_valid, bA.rsp_ready, bA.req_valid, bA.req_ready,
          bA.req_addr, bA.rsp_addr, bA.rsp_data, bA.load_en, bA.flush);
      mon(1, 2, 3, bB.rsp_valid, bB.rsp_ready, bB.req_valid, bB.req_ready,
          bB.req_addr, bB.rsp_addr, bB.rsp_data, bB.load_en, bB.flush);
      if (bA.load_en) model[bA.load_addr] = bA.load_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input logic v, input logic [8:0] a);
    if (id == 0) begin bA.req_valid = v; bA.req_addr = a; end
    else         begin bB.req_valid = v; bB.req_addr = a; end
  endtask

  task automatic setRdy(input int id, input logic r);
    if (id == 0) bA.rsp_ready = r;
    else         bB.rsp_ready = r;
  endtask

  task automatic setFlush(input int id, input logic f);
    if (id == 0) bA.flush = f;
    else         bB.flush = f;
  endtask

  task automatic setLoad(input logic en, input logic [8:0] a, input logic [31:0] d);
    bA.load_en = en; bA.load_addr = a; bA.load_data = d;
    bB.load_en = en; bB.load_addr = a; bB.load_data = d;
  endtask

  task automatic waitIdle(input int id);
    int n;
    n = 0;
    while (sbq[id].size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk($sformatf("drain%0d", id), sbq[id].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int a0;
    int n;
    accCnt[0] = 0;
    accCnt[1] = 0;
    setLoad(1'b0, 9'd0, 32'd0);
    setReq(0, 1'b0, 9'd0);
    setReq(1, 1'b0, 9'd0);
    setFlush(0, 1'b0);
    setFlush(1, 1'b0);
    setRdy(0, 1'b1);
    setRdy(1, 1'b1);

    // Power-on reset
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rstA_rsp_valid", bA.rsp_valid, 0);
    chk("rstA_rsp_data", bA.rsp_data, 0);
    chk("rstA_rsp_addr", bA.rsp_addr, 0);
    chk("rstA_req_ready", bA.req_ready, 1);
    chk("rstB_rsp_valid", bB.rsp_valid, 0);
    chk("rstB_rsp_data", bB.rsp_data, 0);
    chk("rstB_req_ready", bB.req_ready, 1);

    // Program load with a fetch pending: nothing may be accepted
    a0 = accCnt[0];
    setReq(0, 1'b1, 9'd0);
    for (int i = 0; i < 4; i++) begin
      setLoad(1'b1, 9'(i), 32'h2000_0001 + 32'(i));
      tick();
    end
    setLoad(1'b0, 9'd0, 32'd0);
    setReq(0, 1'b0, 9'd0);
    chk("load_no_accept", accCnt[0] - a0, 0);

    // Streaming, READ_LAT=1
    s = seen[0].size();
    for (int i = 0; i < 4; i++) begin
      setReq(0, 1'b1, 9'(i));
      tick();
      if (i == 0) chk("stream_first_rsp", bA.rsp_valid, 1);
    end
    setReq(0, 1'b0, 9'd0);
    waitIdle(0);
    chk("stream_count", seen[0].size() - s, 4);
    for (int k = 0; k < 4; k++) chk("stream_data", seen[0][s + k], 32'h2000_0001 + 32'(k));

    // Backpressure: buffer fills, then req_ready drops
    setRdy(0, 1'b0);
    a0 = accCnt[0];
    for (int i = 0; i < 3; i++) begin
      setReq(0, 1'b1, 9'(i));
      tick();
    end
    tick();
    chk("bp_accepted", accCnt[0] - a0, 2);
    chk("bp_req_ready", bA.req_ready, 0);
    s = seen[0].size();
    setRdy(0, 1'b1);
    n = 0;
    while (accCnt[0] - a0 < 3 && n < 10) begin
      tick();
      n++;
    end
    setReq(0, 1'b0, 9'd0);
    chk("bp_third_accept", accCnt[0] - a0, 3);
    waitIdle(0);
    chk("bp_count", seen[0].size() - s, 3);
    for (int k = 0; k < 3; k++) chk("bp_data", seen[0][s + k], 32'h2000_0001 + 32'(k));

    // Flush with two words outstanding
    setRdy(0, 1'b0);
    setReq(0, 1'b1, 9'd0);
    tick();
    setReq(0, 1'b1, 9'd1);
    tick();
    setReq(0, 1'b0, 9'd0);
    s = seen[0].size();
    setFlush(0, 1'b1);
    tick();
    setFlush(0, 1'b0);
    chk("flush_rsp_valid", bA.rsp_valid, 0);
    setRdy(0, 1'b1);
    setReq(0, 1'b1, 9'd3);
    tick();
    setReq(0, 1'b0, 9'd0);
    chk("flush_next_addr", bA.rsp_addr, 3);
    chk("flush_next_data", bA.rsp_data, 32'h2000_0004);
    waitIdle(0);
    chk("flush_count", seen[0].size() - s, 1);

    // Load while a fetch of the same word is in flight
    s = seen[0].size();
    setReq(0, 1'b1, 9'd1);
    tick();
    setReq(0, 1'b0, 9'd0);
    setLoad(1'b1, 9'd1, 32'hDEAD_BEEF);
    tick();
    setLoad(1'b0, 9'd0, 32'd0);
    setReq(0, 1'b1, 9'd1);
    tick();
    setReq(0, 1'b0, 9'd0);
    waitIdle(0);
    chk("lif_count", seen[0].size() - s, 2);
    chk("lif_old", seen[0][s], 32'h2000_0002);
    chk("lif_new", seen[0][s + 1], 32'hDEAD_BEEF);

    // READ_LAT=2 streaming
    s = seen[1].size();
    for (int i = 0; i < 8; i++) begin
      setReq(1, 1'b1, 9'(i % 4));
      tick();
      if (i == 0) chk("lat2_early", bB.rsp_valid, 0);
      if (i == 1) chk("lat2_first", bB.rsp_valid, 1);
    end
    setReq(1, 1'b0, 9'd0);
    waitIdle(1);
    chk("lat2_count", seen[1].size() - s, 8);
    chk("lat2_data0", seen[1][s], 32'h2000_0001);
    chk("lat2_data1", seen[1][s + 1], 32'hDEAD_BEEF);

    // READ_LAT=2 with random valid and stalls
    for (int i = 0; i < 60; i++) begin
      setReq(1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 3)));
      setRdy(1, 1'($urandom_range(0, 1)));
      tick();
    end
    setReq(1, 1'b0, 9'd0);
    setRdy(1, 1'b1);
    waitIdle(1);

    // Reset with words outstanding in both DUTs
    setRdy(0, 1'b0);
    setRdy(1, 1'b0);
    setReq(0, 1'b1, 9'd0);
    setReq(1, 1'b1, 9'd1);
    tick();
    setReq(0, 1'b1, 9'd2);
    tick();
    setReq(0, 1'b0, 9'd0);
    setReq(1, 1'b0, 9'd0);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("mrstA_rsp_valid", bA.rsp_valid, 0);
    chk("mrstA_req_ready", bA.req_ready, 1);
    chk("mrstB_rsp_valid", bB.rsp_valid, 0);
    chk("mrstB_req_ready", bB.req_ready, 1);
    s = seen[0].size();
    n = seen[1].size();
    setRdy(0, 1'b1);
    setRdy(1, 1'b1);
    repeat (5) tick();
    chk("mrstA_stray", seen[0].size() - s, 0);
    chk("mrstB_stray", seen[1].size() - n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Parametrised instruction memory for the Gold CMP core; next generation of the asynchronous-read instruction ROM.
- Adds a synchronous pipelined read (1 or 2 cycles) behind a valid/ready request port and a buffered valid/ready response port.
- Adds a program-load write port and a flush for branch redirect.
- Sits between the IF stage and instruction storage; the IF stage may stall without losing fetched words.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 9, word address width; memory depth is 2**ADDR_W (512 by default).
- READ_LAT, 1, accept-to-response latency in cycles; legal values are 1 or 2.
- RSP_DEPTH, 2, response buffer entries; must be >= READ_LAT (RSP_DEPTH >= READ_LAT+1 gives full throughput under single-cycle stalls).

Ports:
- clk  in  1  single clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  load word address.
- load_data  in  DATA_W  load word.
- flush  in  1  discards all in-flight and buffered responses.
- req_valid  in  1  fetch request valid.
- req_addr  in  ADDR_W  fetch word address (PC[...] word index).
- req_ready  out  1  request accepted when req_valid && req_ready at the rising edge.
- rsp_valid  out  1  response word available.
- rsp_data  out  DATA_W  fetched instruction.
- rsp_addr  out  ADDR_W  address that produced rsp_data.
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready at the rising edge.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Pipeline valid bits, buffer pointers and the outstanding counter clear to 0.
  - rsp_valid=0, rsp_data=0, rsp_addr=0.
  - req_ready=1 from the first cycle after reset deasserts.
  - Memory array contents are NOT reset.
- Reset mid-operation drops every in-flight word; no response emerges afterwards.
- Outstanding counter:
  - outstanding = words in the read pipeline + words in the response buffer, range 0..RSP_DEPTH.
  - On the same edge: +1 on accept, -1 on pop; a simultaneous accept and pop leaves it unchanged.
- req_ready = !load_en && !flush && (outstanding < RSP_DEPTH). It is combinational and does not depend on req_valid.
- Latency:
  - A request accepted at edge E writes its word into the response buffer at edge E+READ_LAT-1.
  - rsp_valid is high in the cycle after that edge (READ_LAT=1: the cycle right after acceptance).
  - READ_LAT=2 inserts one pipeline register (data + addr + valid) between the array read and the buffer.
- Response buffer:
  - Circular FIFO, RSP_DEPTH entries, first-word-fall-through from registered storage.
  - rsp_valid = (buffer count != 0). rsp_data and rsp_addr always show the head entry; they hold their last value when empty.
  - Order is strict: responses leave in request order.
  - Overflow cannot occur by construction. An assertion fires if the buffer is written while full.
  - Pop while empty is ignored.
  - Read and write pointers wrap modulo RSP_DEPTH.
- Load:
  - load_en=1 writes MEM[load_addr]=load_data at the edge.
  - Load has priority: req_ready=0 while load_en=1, and no fetch is accepted that cycle.
  - Words already in flight are unaffected and return their pre-load data.
  - A fetch accepted in any later cycle returns the new data; there is no read-during-write hazard.
- Flush:
  - At an edge with flush=1: all pipeline valid bits and the buffer clear, and outstanding=0.
  - rsp_valid=0 in the next cycle.
  - A pop on the flush edge is harmless. No request is accepted on the flush edge.
  - A flush during load_en=1 still performs the write.
- rsp_ready held low: the buffer fills, then req_ready drops. No data is lost or duplicated.

Decomposition:
- Shared package imem_pkg:
  - Defaults IMEM_DATA_W=32, IMEM_ADDR_W=9.
  - Legal READ_LAT range.
  - Typedef of a response entry {addr, data}.
- One natural sub-module: imem_rsp_fifo, the parametrised FWFT circular buffer with count, push, pop and clear.
- The top level holds the array, the read pipeline, the outstanding counter and the handshake logic.

Test Plan:
- Reset and load:
  - Assert reset_n=0 mid-stream with 2 words outstanding, then release: rsp_valid=0, req_ready=1, no stray response.
  - Load 0x20000001..0x20000004 into addr 0..3; none of those 4 cycles accepts a fetch (req_ready=0).
- Streaming at READ_LAT=1, RSP_DEPTH=2, rsp_ready=1:
  - Request addr 0,1,2,3 on consecutive cycles.
  - rsp_data sequence is 0x20000001..0x20000004, one per cycle, first one cycle after the first accept; req_ready stays 1.
- Backpressure:
  - Hold rsp_ready=0 and issue addr 0,1,2.
  - Exactly 2 are accepted, then req_ready=0.
  - Raise rsp_ready: responses for addr 0 then 1, then addr 2 is accepted. Order is preserved and nothing is duplicated.
- Flush:
  - Assert flush with 2 words outstanding, then request addr 3.
  - No response for the flushed words; the next rsp_data is 0x20000004 with rsp_addr=3.
- Load during flight:
  - Accept a fetch of addr 1, then load addr 1 with 0xDEADBEEF in the next cycle, then fetch addr 1 again.
  - Responses are 0x20000002 then 0xDEADBEEF.
- READ_LAT=2, RSP_DEPTH=3:
  - Stream 8 addresses.
  - The first response arrives 2 cycles after the first accept, then one per cycle; outstanding never exceeds 3.
